gpi_event_capture: RTL and testbench

//  Front end for the MCS GPI1 input. Synchronises and debounces WIDTH raw

---
 rtl/gpi_event_capture_pkg.sv | 16 +
 rtl/debounce_bit.sv | 40 ++++
 rtl/gpi_event_capture.sv | 75 +++++++
 tb/tb_gpi_event_capture.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/gpi_event_capture_pkg.sv
// Shared definitions for the GPI event-capture front end: GPO1 command field
// positions and the edge-select encoding.
package gpi_event_capture_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_sel_e;

  localparam int SEL_BIT  = 7;
  localparam int EDGE_MSB = 6;
  localparam int EDGE_LSB = 5;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: metastability chain, stability counter and accepted level.
// 'accept' pulses combinationally on the cycle 'stable' takes the new value.
module debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic accept
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   s;

  assign s      = sync_q[SYNC_STAGES-1];
  assign accept = (s != stable) && (cnt == CNT_LAST);

  // NOTE: every flop, including the sync chain, is cleared so a reset mid-debounce leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of its peers.
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      // Cleared on match and on accept, so the counter can never wrap.
      if ((s == stable) || accept) cnt <= '0;
      else                         cnt <= cnt + CNT_W'(1);
      if (accept) stable <= s;
    end
  end

endmodule

// File: rtl/gpi_event_capture.sv
// MCS GPI1 front end: debounced levels or a read-to-clear snapshot of sticky
// edge events, selected and controlled by the GPO1 command word.
module gpi_event_capture
  import gpi_event_capture_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] gpo_cmd,
  output logic [WIDTH-1:0] gpi_data,
  output logic             evt_pending
);

  logic [WIDTH-1:0] stable, accept, rise, fall, new_set;
  logic [WIDTH-1:0] live_q, live_d, snap_q, snap_d;
  logic             prev_sel, sel, clear;
  edge_sel_e        edge_sel;
  logic             unused_cmd_bits;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (Clk),
      .rst_n (Reset),
      .raw   (raw_in[i]),
      .stable(stable[i]),
      .accept(accept[i])
    );
  end

  // On an accept the bit flips, so the old level tells the edge direction.
  assign rise            = accept & ~stable;
  assign fall            = accept & stable;
  assign unused_cmd_bits = ^gpo_cmd[EDGE_LSB-1:0];

  // NOTE: all outputs get a default first so no path infers a latch.
  always_comb begin
    sel      = gpo_cmd[SEL_BIT];
    edge_sel = edge_sel_e'(gpo_cmd[EDGE_MSB:EDGE_LSB]);
    clear    = sel & ~prev_sel;
    new_set  = '0;
    case (edge_sel)
      EDGE_RISE: new_set = rise;
      EDGE_FALL: new_set = fall;
      EDGE_BOTH: new_set = rise | fall;
      default:   new_set = '0;
    endcase
    // On a clear every old flag moves to the snapshot; only same-cycle edges stay live.
    live_d = clear ? new_set : (live_q | new_set);
    snap_d = clear ? live_q  : snap_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      prev_sel    <= 1'b0;
      live_q      <= '0;
      snap_q      <= '0;
      gpi_data    <= '0;
      evt_pending <= 1'b0;
    end else begin
      prev_sel    <= sel;
      live_q      <= live_d;
      snap_q      <= snap_d;
      gpi_data    <= sel ? snap_d : stable;
      evt_pending <= |live_q;
    end
  end

endmodule

// File: tb/tb_gpi_event_capture.sv
// Directed bench for gpi_event_capture with DEBOUNCE_CYCLES=4, SYNC_STAGES=2
// (raw-to-gpi_data latency of 7 cycles).
module tb_gpi_event_capture;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] raw_in;
  logic [7:0] gpo_cmd;
  logic [7:0] gpi_data;
  logic       evt_pending;

  int tests = 0;
  int fails = 0;

  gpi_event_capture #(
    .WIDTH          (8),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .raw_in     (raw_in),
    .gpo_cmd    (gpo_cmd),
    .gpi_data   (gpi_data),
    .evt_pending(evt_pending)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset with all inputs high, then full latency to levels
    Reset   = 1'b0;
    raw_in  = 8'hFF;
    gpo_cmd = 8'h00;
    tick(3);
    check("rst_gpi", gpi_data, 8'h00);
    check("rst_evt", {7'd0, evt_pending}, 8'h00);
    Reset = 1'b1;
    check("rel_gpi", gpi_data, 8'h00);
    check("rel_evt", {7'd0, evt_pending}, 8'h00);
    tick(6);
    check("boot_gpi_early", gpi_data, 8'h00);
    tick(1);
    check("boot_gpi", gpi_data, 8'hFF);
    check("boot_evt", {7'd0, evt_pending}, 8'h01);

    // boot dummy read-to-clear
    gpo_cmd = 8'h80;
    tick(1);
    check("boot_snap", gpi_data, 8'hFF);
    tick(1);
    check("boot_evt_clr", {7'd0, evt_pending}, 8'h00);
    gpo_cmd = 8'h00;
    raw_in  = 8'h00;
    tick(10);
    check("fall_norise_gpi", gpi_data, 8'h00);
    check("fall_norise_evt", {7'd0, evt_pending}, 8'h00);

    // 2: 3-cycle glitch rejected, then a held level accepted
    raw_in = 8'h01;
    tick(3);
    raw_in = 8'h00;
    tick(10);
    check("glitch_gpi", gpi_data, 8'h00);
    check("glitch_evt", {7'd0, evt_pending}, 8'h00);
    raw_in = 8'h01;
    tick(6);
    check("hold_gpi_early", gpi_data, 8'h00);
    tick(1);
    check("hold_gpi", gpi_data, 8'h01);
    check("hold_evt", {7'd0, evt_pending}, 8'h01);

    // 3: rise-only events, snapshot, then re-clear gives empty snapshot
    raw_in = 8'h00; tick(10);
    raw_in = 8'h05; tick(10);
    raw_in = 8'h00; tick(10);
    check("lvl_back_gpi", gpi_data, 8'h00);
    gpo_cmd = 8'h80;
    tick(1);
    check("snap05", gpi_data, 8'h05);
    tick(1);
    check("snap05_evt", {7'd0, evt_pending}, 8'h00);
    gpo_cmd = 8'h00;
    tick(1);
    check("sel0_levels", gpi_data, 8'h00);
    gpo_cmd = 8'h80;
    tick(1);
    check("snap_empty", gpi_data, 8'h00);

    // 4: bit3 rise accepted on the same cycle as SEL 0->1
    gpo_cmd = 8'h00;
    raw_in  = 8'h01;
    tick(10);
    raw_in = 8'h09;
    tick(5);
    gpo_cmd = 8'h80;
    tick(1);
    check("race_snap", gpi_data, 8'h01);
    check("race_evt0", {7'd0, evt_pending}, 8'h01);
    tick(1);
    check("race_evt1", {7'd0, evt_pending}, 8'h01);
    gpo_cmd = 8'h00;
    tick(1);
    check("race_levels", gpi_data, 8'h09);
    gpo_cmd = 8'h80;
    tick(1);
    check("race_live", gpi_data, 8'h08);
    tick(1);
    check("race_evt_clr", {7'd0, evt_pending}, 8'h00);

    // 5: events disabled, then both edges, then fall only
    gpo_cmd = 8'h60;
    raw_in  = 8'hAA; tick(10);
    check("off_aa", gpi_data, 8'hAA);
    raw_in  = 8'h00; tick(10);
    check("off_00", gpi_data, 8'h00);
    raw_in  = 8'hAA; tick(10);
    check("off_aa2", gpi_data, 8'hAA);
    check("off_evt", {7'd0, evt_pending}, 8'h00);
    gpo_cmd = 8'h40;
    raw_in  = 8'hA8; tick(10);
    check("both_gpi", gpi_data, 8'hA8);
    check("both_evt", {7'd0, evt_pending}, 8'h01);
    gpo_cmd = 8'hC0;
    tick(1);
    check("both_snap", gpi_data, 8'h02);
    gpo_cmd = 8'h20;
    raw_in  = 8'h29; tick(10);
    gpo_cmd = 8'hA0;
    tick(1);
    check("fall_snap", gpi_data, 8'h80);

    // 6: reset mid-debounce and mid-SEL, then no stale event
    gpo_cmd = 8'h20;
    tick(1);
    check("pre_rst_gpi", gpi_data, 8'h29);
    raw_in = 8'hFF;
    tick(4);
    gpo_cmd = 8'hA0;
    #2 Reset = 1'b0;
    #1;
    check("async_rst_gpi", gpi_data, 8'h00);
    check("async_rst_evt", {7'd0, evt_pending}, 8'h00);
    @(negedge Clk);
    raw_in  = 8'h00;
    gpo_cmd = 8'h00;
    Reset   = 1'b1;
    tick(10);
    check("post_rst_gpi", gpi_data, 8'h00);
    check("post_rst_evt", {7'd0, evt_pending}, 8'h00);
    gpo_cmd = 8'h80;
    tick(1);
    check("post_rst_snap", gpi_data, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
